// File: rtl/bram_log_reader.sv
// bram_log_reader: streams N logged AXI transaction entries out of a
// read-only BRAM (1-cycle read latency) through a 2-deep output FIFO with a
// valid/ready handshake. A read still in flight is presented directly at the
// FIFO head while the FIFO is empty, so the first beat appears two cycles
// after Start and a steady Ready gives one entry per cycle.
module bram_log_reader #(
  parameter int unsigned  AXI_ADDR_BITW     = 32,
  parameter int unsigned  AXI_ID_BITW       = 8,
  parameter int unsigned  AXI_LEN_BITW      = 8,
  parameter int unsigned  TIMESTAMP_BITW    = 32,
  parameter int unsigned  LOGGING_DATA_BITW = 96,
  parameter int unsigned  NUM_SER_BRAMS     = 12,
  localparam int unsigned ENTRY_MAX         = 1024 * NUM_SER_BRAMS,
  localparam int unsigned CNT_BITW          = $clog2(ENTRY_MAX)
) (
  input  logic                         Clk_CI,
  input  logic                         Rst_RBI,
  input  logic                         Start_SI,
  input  logic [CNT_BITW:0]            NumEntries_DI,
  input  logic                         Abort_SI,
  output logic                         Busy_SO,
  output logic                         Done_SO,
  output logic                         BramEn_SO,
  output logic [CNT_BITW-1:0]          BramAddr_DO,
  input  logic [LOGGING_DATA_BITW-1:0] BramRd_DI,
  output logic                         Valid_SO,
  input  logic                         Ready_SI,
  output logic [TIMESTAMP_BITW-1:0]    Timestamp_DO,
  output logic [AXI_ADDR_BITW-1:0]     AxiAddr_DO,
  output logic [AXI_ID_BITW-1:0]       AxiId_DO,
  output logic [AXI_LEN_BITW-1:0]      AxiLen_DO,
  output logic                         Last_SO
);

  localparam int unsigned NW = CNT_BITW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [NW-1:0]                n_q, issue_q, pop_q;
  logic [NW-1:0]                n_clamp;
  logic                         pend_q;
  logic [1:0]                   fifo_cnt_q, fifo_cnt_d;
  logic                         fifo_rd_q;
  logic [LOGGING_DATA_BITW-1:0] fifo_mem [2];

  logic                         start_acc;
  logic                         head_valid;
  logic [LOGGING_DATA_BITW-1:0] head;
  logic                         pop;
  logic                         last_pop;
  logic                         issue;
  logic [2:0]                   occ;
  logic                         fifo_wr;
  logic                         fifo_adv;
  logic                         wr_idx;
  logic                         unused_bits;

  // Datapath control: clamp, head select, handshake, read-issue throttle
  always_comb begin
    n_clamp    = (NumEntries_DI > NW'(ENTRY_MAX)) ? NW'(ENTRY_MAX) : NumEntries_DI;
    start_acc  = (state_q == IDLE) && Start_SI && !Abort_SI;
    head_valid = (state_q == READ) && ((fifo_cnt_q != 2'd0) || pend_q);
    head       = (fifo_cnt_q != 2'd0) ? fifo_mem[fifo_rd_q] : BramRd_DI;
    pop        = head_valid && Ready_SI;
    last_pop   = pop && (pop_q == (n_q - NW'(1)));
    // Entries held plus in flight, minus the one leaving, must leave room
    occ        = 3'(fifo_cnt_q) + 3'(pend_q) - 3'(pop);
    issue      = (state_q == READ) && !Abort_SI && (issue_q < n_q) && (occ < 3'd2);
    // A returning read goes into the FIFO unless it is consumed straight away
    fifo_wr    = pend_q && !(pop && (fifo_cnt_q == 2'd0));
    fifo_adv   = pop && (fifo_cnt_q != 2'd0);
    wr_idx     = fifo_rd_q ^ fifo_cnt_q[0];
    fifo_cnt_d = fifo_cnt_q + 2'(fifo_wr) - 2'(fifo_adv);
  end

  assign unused_bits = ^head;

  // FSM state register
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = (n_clamp == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (Abort_SI) begin
          state_d = IDLE;
        end else if (last_pop) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: status, BRAM port and decoded FIFO head
  always_comb begin
    Busy_SO      = (state_q != IDLE);
    Done_SO      = (state_q == DONE) && !Abort_SI;
    BramEn_SO    = issue;
    BramAddr_DO  = issue ? issue_q[CNT_BITW-1:0] : '0;
    Valid_SO     = head_valid;
    Last_SO      = head_valid && (pop_q == (n_q - NW'(1)));
    Timestamp_DO = '0;
    AxiAddr_DO   = '0;
    AxiId_DO     = '0;
    AxiLen_DO    = '0;
    if (head_valid) begin
      Timestamp_DO = head[0 +: TIMESTAMP_BITW];
      AxiAddr_DO   = head[32 +: AXI_ADDR_BITW];
      AxiId_DO     = head[64 +: AXI_ID_BITW];
      AxiLen_DO    = head[64 + AXI_ID_BITW +: AXI_LEN_BITW];
    end
  end

  // Counters, in-flight flag and FIFO pointers; abort or leaving READ flushes
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      n_q        <= '0;
      issue_q    <= '0;
      pop_q      <= '0;
      pend_q     <= 1'b0;
      fifo_cnt_q <= 2'd0;
      fifo_rd_q  <= 1'b0;
    end else begin
      pend_q <= issue;
      if (start_acc) begin
        n_q        <= n_clamp;
        issue_q    <= '0;
        pop_q      <= '0;
        fifo_cnt_q <= 2'd0;
        fifo_rd_q  <= 1'b0;
      end else if ((state_q != READ) || Abort_SI) begin
        fifo_cnt_q <= 2'd0;
        fifo_rd_q  <= 1'b0;
      end else begin
        issue_q    <= issue_q + NW'(issue);
        pop_q      <= pop_q + NW'(pop);
        fifo_cnt_q <= fifo_cnt_d;
        if (fifo_adv) begin
          fifo_rd_q <= ~fifo_rd_q;
        end
      end
    end
  end

  // FIFO storage; contents are only observed while the count says valid
  always_ff @(posedge Clk_CI) begin
    if (fifo_wr) begin
      fifo_mem[wr_idx] <= BramRd_DI;
    end
  end

endmodule

// File: tb/tb_bram_log_reader.sv
// Directed testbench for bram_log_reader with a behavioural 1-cycle BRAM.
module tb_bram_log_reader;

  localparam int unsigned ENTRY_MAX = 1024 * 12;
  localparam int unsigned CNT_BITW  = 14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [14:0] num_entries;
  logic        abort;
  logic        busy, done, bram_en;
  logic [13:0] bram_addr;
  logic [95:0] bram_rd = '0;
  logic        valid;
  logic        ready;
  logic [31:0] ts, addr;
  logic [7:0]  id, len;
  logic        last;
  logic [79:0] obs;

  int tests_run    = 0;
  int tests_failed = 0;

  bram_log_reader dut (
    .Clk_CI        (clk),
    .Rst_RBI       (rst_n),
    .Start_SI      (start),
    .NumEntries_DI (num_entries),
    .Abort_SI      (abort),
    .Busy_SO       (busy),
    .Done_SO       (done),
    .BramEn_SO     (bram_en),
    .BramAddr_DO   (bram_addr),
    .BramRd_DI     (bram_rd),
    .Valid_SO      (valid),
    .Ready_SI      (ready),
    .Timestamp_DO  (ts),
    .AxiAddr_DO    (addr),
    .AxiId_DO      (id),
    .AxiLen_DO     (len),
    .Last_SO       (last)
  );

  always #5 clk = ~clk;

  assign obs = {len, id, addr, ts};

  // Expected decoded fields of entry k: {len, id, addr, ts}
  function automatic logic [79:0] exp_fields(input int k);
    logic [7:0]  e_len;
    logic [7:0]  e_id;
    logic [31:0] e_addr;
    logic [31:0] e_ts;
    e_len  = 8'(k);
    e_id   = 8'(32'hA0 + k);
    e_addr = 32'(32'h1000 + 4 * k);
    e_ts   = 32'(k);
    return {e_len, e_id, e_addr, e_ts};
  endfunction

  // BRAM model; upper bits carry a marker the decoder must ignore
  always @(posedge clk) begin
    if (bram_en) bram_rd <= {16'hBEEF, exp_fields(int'(bram_addr))};
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; num_entries = '0; abort = 1'b0; ready = 1'b0;
    #3;
    tests_run++;
    if ({busy, done, bram_en, valid, last, bram_addr, obs} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b done=%b en=%b valid=%b last=%b addr=%h data=%h, want all 0",
               busy, done, bram_en, valid, last, bram_addr, obs);
    end
    cyc; cyc;
    rst_n = 1'b1;
    cyc; #1;
    tests_run++;
    if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got busy=%b valid=%b done=%b, want 0 0 0", busy, valid, done);
    end
  endtask

  task automatic test_basic;
    start = 1'b1; num_entries = 15'd4; ready = 1'b1;
    cyc; start = 1'b0; #1;
    tests_run++;
    if (busy !== 1'b1 || bram_en !== 1'b1 || bram_addr !== 14'd0 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_first_issue: got busy=%b en=%b addr=%0d valid=%b, want 1 1 0 0",
               busy, bram_en, bram_addr, valid);
    end
    for (int k = 0; k < 4; k++) begin
      cyc; #1;
      tests_run++;
      if (valid !== 1'b1 || obs !== exp_fields(k) || last !== (k == 3)) begin
        tests_failed++;
        $display("FAIL basic_beat%0d: got valid=%b data=%h last=%b, want 1 %h %b",
                 k, valid, obs, last, exp_fields(k), (k == 3));
      end
    end
    cyc; #1;
    tests_run++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done: got done=%b valid=%b, want 1 0", done, valid);
    end
    cyc; #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_idle: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_stall;
    int beat = 0;
    int issued = 0;
    bit stalled = 1'b0;
    bit seen_done = 1'b0;
    logic [79:0] prev = '0;
    start = 1'b1; num_entries = 15'd8; ready = 1'b0;
    cyc; start = 1'b0;
    for (int cy = 0; cy < 80 && !seen_done; cy++) begin
      ready = (cy % 2) == 0;
      start = (cy == 4);
      num_entries = (cy == 4) ? 15'd3 : 15'd8;
      #1;
      if (bram_en) begin
        tests_run++;
        if (bram_addr !== 14'(issued)) begin
          tests_failed++;
          $display("FAIL stall_issue_addr: got %0d, want %0d", bram_addr, issued);
        end
        issued++;
      end
      if (valid && stalled) begin
        tests_run++;
        if (obs !== prev) begin
          tests_failed++;
          $display("FAIL stall_hold: got %h, want %h", obs, prev);
        end
      end
      if (valid && ready) begin
        tests_run++;
        if (obs !== exp_fields(beat) || last !== (beat == 7)) begin
          tests_failed++;
          $display("FAIL stall_beat%0d: got data=%h last=%b, want %h %b",
                   beat, obs, last, exp_fields(beat), (beat == 7));
        end
        beat++;
      end
      tests_run++;
      if (issued - beat > 2) begin
        tests_failed++;
        $display("FAIL stall_occupancy: got %0d outstanding, want <= 2", issued - beat);
      end
      stalled = valid && !ready;
      prev = obs;
      if (done) seen_done = 1'b1;
      cyc;
    end
    start = 1'b0; ready = 1'b0;
    tests_run++;
    if (beat != 8 || issued != 8 || !seen_done) begin
      tests_failed++;
      $display("FAIL stall_totals: got beats=%0d issued=%0d done=%b, want 8 8 1", beat, issued, seen_done);
    end
  endtask

  task automatic test_zero;
    start = 1'b1; num_entries = 15'd0; ready = 1'b1;
    cyc; start = 1'b0; #1;
    tests_run++;
    if (done !== 1'b1 || bram_en !== 1'b0 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_done: got done=%b en=%b valid=%b, want 1 0 0", done, bram_en, valid);
    end
    cyc; #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_idle: got done=%b busy=%b valid=%b, want 0 0 0", done, busy, valid);
    end
  endtask

  task automatic test_clamp;
    int beats = 0;
    int bad = 0;
    int last_addr = -1;
    int last_cnt = 0;
    int last_at = -1;
    bit seen_done = 1'b0;
    start = 1'b1; num_entries = 15'(ENTRY_MAX + 5); ready = 1'b1;
    cyc; start = 1'b0;
    for (int cy = 0; cy < int'(ENTRY_MAX) + 40 && !seen_done; cy++) begin
      #1;
      if (bram_en) last_addr = int'(bram_addr);
      if (valid) begin
        if (obs !== exp_fields(beats)) bad++;
        if (last) begin
          last_cnt++;
          last_at = beats;
        end
        beats++;
      end
      if (done) seen_done = 1'b1;
      cyc;
    end
    tests_run++;
    if (beats != int'(ENTRY_MAX) || !seen_done) begin
      tests_failed++;
      $display("FAIL clamp_beats: got %0d done=%b, want %0d 1", beats, seen_done, ENTRY_MAX);
    end
    tests_run++;
    if (last_addr != int'(ENTRY_MAX) - 1) begin
      tests_failed++;
      $display("FAIL clamp_last_addr: got %0d, want %0d", last_addr, ENTRY_MAX - 1);
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL clamp_data: got %0d bad beats, want 0", bad);
    end
    tests_run++;
    if (last_cnt != 1 || last_at != int'(ENTRY_MAX) - 1) begin
      tests_failed++;
      $display("FAIL clamp_last_flag: got count=%0d at=%0d, want 1 at %0d", last_cnt, last_at, ENTRY_MAX - 1);
    end
  endtask

  task automatic test_abort;
    start = 1'b1; num_entries = 15'd10; ready = 1'b1;
    cyc; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc; #1;
      tests_run++;
      if (valid !== 1'b1 || obs !== exp_fields(k)) begin
        tests_failed++;
        $display("FAIL abort_pre_beat%0d: got valid=%b data=%h, want 1 %h", k, valid, obs, exp_fields(k));
      end
    end
    cyc; abort = 1'b1; ready = 1'b0; #1;
    tests_run++;
    if (done !== 1'b0 || bram_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_cycle: got done=%b en=%b, want 0 0", done, bram_en);
    end
    cyc; abort = 1'b0; #1;
    tests_run++;
    if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: got busy=%b valid=%b done=%b, want 0 0 0", busy, valid, done);
    end
    cyc; #1;
    tests_run++;
    if (valid !== 1'b0 || done !== 1'b0 || bram_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_quiet: got valid=%b done=%b en=%b, want 0 0 0", valid, done, bram_en);
    end
    start = 1'b1; num_entries = 15'd2; ready = 1'b1;
    cyc; start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc; #1;
      tests_run++;
      if (valid !== 1'b1 || obs !== exp_fields(k) || last !== (k == 1)) begin
        tests_failed++;
        $display("FAIL abort_restart_beat%0d: got valid=%b data=%h last=%b, want 1 %h %b",
                 k, valid, obs, last, exp_fields(k), (k == 1));
      end
    end
    cyc; #1;
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_restart_done: got %b, want 1", done);
    end
    cyc;
  endtask

  task automatic test_async_reset;
    start = 1'b1; num_entries = 15'd6; ready = 1'b1;
    cyc; start = 1'b0;
    cyc; cyc;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, bram_en, valid, last, bram_addr, obs} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset_outputs: got busy=%b done=%b en=%b valid=%b last=%b addr=%h data=%h, want all 0",
               busy, done, bram_en, valid, last, bram_addr, obs);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc; #1;
    tests_run++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_quiet: got valid=%b busy=%b, want 0 0", valid, busy);
    end
    start = 1'b1; num_entries = 15'd1;
    cyc; start = 1'b0;
    cyc; #1;
    tests_run++;
    if (valid !== 1'b1 || obs !== exp_fields(0) || last !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset_restart: got valid=%b data=%h last=%b, want 1 %h 1",
               valid, obs, last, exp_fields(0));
    end
    cyc; #1;
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset_done: got %b, want 1", done);
    end
    cyc;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_zero;
    test_clamp;
    test_abort;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bram_log_reader.md
BRAM_LOG_READER -- requirements
Module: bram_log_reader

Interface
REQ-001 Parameter AXI_ADDR_BITW, 32, address field width of one log entry.
REQ-002 Parameter AXI_ID_BITW, 8, ID field width of one log entry.
REQ-003 Parameter AXI_LEN_BITW, 8, burst-length field width of one log entry.
REQ-004 Parameter TIMESTAMP_BITW, 32, timestamp field width of one log entry.
REQ-005 Parameter LOGGING_DATA_BITW, 96, entry width; SHALL be at least 64+AXI_ID_BITW+AXI_LEN_BITW.
REQ-006 Parameter NUM_SER_BRAMS, 12, log depth in 1024-entry units; CNT_BITW = log2(1024*NUM_SER_BRAMS), ENTRY_MAX = 1024*NUM_SER_BRAMS.
REQ-007 Clocking SHALL be exactly as follows: one clock; reset is asynchronous and active-low.
REQ-008 Clk_CI  in  1  sole clock, all state on rising edge.
REQ-009 Rst_RBI  in  1  asynchronous active-low reset.
REQ-010 Start_SI  in  1  begin reading; sampled only in IDLE.
REQ-011 NumEntries_DI  in  CNT_BITW+1  number of entries to read, sampled with Start_SI.
REQ-012 Abort_SI  in  1  cancel current readout.
REQ-013 Busy_SO  out  1  high in any state other than IDLE.
REQ-014 Done_SO  out  1  one-cycle pulse at readout completion.
REQ-015 BramEn_SO  out  1  BRAM read enable (port is read-only, 1-cycle read latency).
REQ-016 BramAddr_DO  out  CNT_BITW  entry index to read.
REQ-017 BramRd_DI  in  LOGGING_DATA_BITW  BRAM read data, valid the cycle after BramEn_SO.
REQ-018 Valid_SO / Ready_SI  out / in  1 / 1  output entry handshake.
REQ-019 Timestamp_DO, AxiAddr_DO, AxiId_DO, AxiLen_DO  out  field widths  decoded entry fields.
REQ-020 Last_SO  out  1  high with the final entry of a readout.

Function
REQ-021 Entry decode: Timestamp=[TIMESTAMP_BITW-1:0], AxiAddr=[63:32], AxiId=[64+AXI_ID_BITW-1:64], AxiLen=next AXI_LEN_BITW bits; other bits ignored.
REQ-022 States: IDLE, READ, DONE.
REQ-023 IDLE: Start_SI=1 -> latch N=min(NumEntries_DI, ENTRY_MAX), clear issue and pop counters, go READ; N=0 -> go DONE directly.
REQ-024 READ: read issued (BramEn_SO=1, BramAddr_DO=issue count) iff issued<N and (FIFO occupancy + in-flight reads - pop this cycle) < 2.
REQ-025 Returned data SHALL be written into a 2-entry output FIFO on the edge after the read issue; FIFO head drives outputs.
REQ-026 Valid_SO = FIFO not empty; pop on Valid_SO & Ready_SI; outputs SHALL hold stable while Valid_SO & ~Ready_SI.
REQ-027 With Ready_SI held high, throughput SHALL be one entry per cycle; first Valid_SO 2 cycles after the Start cycle.
REQ-028 Last_SO = Valid_SO & (popped count == N-1).
REQ-029 READ -> DONE on the pop of entry N-1; DONE asserts Done_SO for one cycle and returns to IDLE.
REQ-030 Abort_SI in READ or DONE: next state IDLE, FIFO flushed, in-flight read data discarded, no Done_SO; Abort_SI overrides Start_SI in IDLE.
REQ-031 Start_SI outside IDLE SHALL be ignored.
REQ-032 Entries SHALL be delivered in address order 0..N-1; no entry duplicated or dropped.

Reset
REQ-033 Rst_RBI low: state IDLE, counters 0, FIFO empty, in-flight cleared; Busy_SO, Done_SO, BramEn_SO, Valid_SO, Last_SO = 0; data outputs 0.
REQ-034 Reset mid-readout SHALL abort immediately; data returning after reset release SHALL be discarded.

Verification
REQ-035 Start, N=4, Ready=1, BRAM entry i = {len=i, id=0xA0+i, addr=0x1000+4i, ts=i}: 4 consecutive beats, first 2 cycles after Start, Last on beat 3, Done 1 cycle after.
REQ-036 N=8, Ready toggling 1/0 each cycle: 8 beats in order, outputs stable while stalled, BramEn_SO never makes FIFO exceed 2.
REQ-037 N=0: Done_SO pulses 1 cycle after Start, Valid_SO never asserts, no BramEn_SO.
REQ-038 NumEntries_DI=ENTRY_MAX+5: exactly ENTRY_MAX beats, last address ENTRY_MAX-1.
REQ-039 Abort_SI after 3 beats of N=10: IDLE next cycle, Valid_SO=0, no Done_SO; new Start N=2 returns entries 0,1.
REQ-040 Rst_RBI low for 1 cycle mid-readout, asynchronously: all outputs 0 immediately; subsequent Start N=1 yields entry 0.
